// File: rtl/shift_register_deserializer.sv
// Serial-to-parallel receiver: collects N LSB-first bits per word and presents each
// completed word on a valid/ready output, flagging words dropped while the consumer stalls.
module shift_register_deserializer #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         si,
    input  logic         bit_en,
    input  logic         clear,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy,
    output logic         overrun
);

    logic [N-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          overrun_q, overrun_d;

    logic [N-1:0]  word;
    logic          consume;
    logic          complete;

    assign word    = {si, sh_q[N-1:1]};
    assign consume = dout_valid_q & dout_ready;

    always_comb begin
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        complete     = 1'b0;

        if (clear) begin
            sh_d      = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (bit_en) begin
            sh_d = word;
            if (cnt_q == CW'(N - 1)) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A completing word may replace the one being consumed this same cycle.
        if (complete) begin
            if (!dout_valid_q || consume) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_q         <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (cnt_q != '0);

endmodule

// File: tb/tb_shift_register_deserializer.sv
// Bench for shift_register_deserializer: directed scenarios plus random traffic, checked
// against a bit-queue reference model with a scoreboard of words the consumer should receive.
module tb_shift_register_deserializer;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         si = 1'b0;
    logic         bit_en = 1'b0;
    logic         clear = 1'b0;
    logic         dout_ready = 1'b0;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         overrun;

    shift_register_deserializer #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .si         (si),
        .bit_en     (bit_en),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: received bits of the partial word, plus the output register view.
    bit bits_q[$];
    int exp_q[$];
    int m_dout  = 0;
    bit m_valid = 1'b0;
    bit m_ovr   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bits_q.delete();
        exp_q.delete();
        m_dout  = 0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_edge();
        bit c;
        bit done;
        int w;
        c    = m_valid && dout_ready;
        done = 1'b0;
        w    = 0;
        if (clear) begin
            bits_q.delete();
            m_ovr = 1'b0;
        end else if (bit_en) begin
            bits_q.push_back(si);
            if (bits_q.size() == N) begin
                foreach (bits_q[i]) w = w + (int'(bits_q[i]) << i);
                bits_q.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || c) begin
                m_dout  = w;
                m_valid = 1'b1;
                exp_q.push_back(w);
            end else begin
                m_ovr = 1'b1;
            end
        end else if (c) begin
            m_valid = 1'b0;
        end
    endtask

    // Called just after a rising edge; inputs apply at the next edge.
    task automatic step(input logic s, input logic be, input logic cl, input logic rd);
        si         = s;
        bit_en     = be;
        clear      = cl;
        dout_ready = rd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic rd_last);
        for (int i = 0; i < N; i++) step(w[i], 1'b1, 1'b0, (i == N - 1) ? rd_last : 1'b0);
    endtask

    // Monitor: state compare every cycle, scoreboard pop on each handshake.
    always @(negedge clk) begin
        chk("dout", 32'(dout), 32'(m_dout));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("busy", 32'(busy), 32'(bits_q.size() != 0));
        if (reset_n && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
            else chk("sb_word", 32'(dout), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);

        // 1,0,1,1 -> 4'b1101; busy after edges 1-3 only
        step(1'b1, 1'b1, 1'b0, 1'b0); chk("busy_e1", 32'(busy), 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b0); chk("busy_e2", 32'(busy), 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b0); chk("busy_e3", 32'(busy), 32'h1);
        chk("valid_early", 32'(dout_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("w1101", 32'(dout), 32'hD);
        chk("w1101_valid", 32'(dout_valid), 32'h1);
        chk("w1101_busy", 32'(busy), 32'h0);

        // one-cycle ready pulse consumes it
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("consume_valid", 32'(dout_valid), 32'h0);
        chk("consume_hold", 32'(dout), 32'hD);

        // overrun while 4'b0011 pending, then clear
        send_word(4'b0011, 1'b0);
        send_word(4'b1111, 1'b0);
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_dout", 32'(dout), 32'h3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovr", 32'(overrun), 32'h0);
        chk("clr_valid", 32'(dout_valid), 32'h1);
        chk("clr_busy", 32'(busy), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // back-to-back 0101 then 1010, ready only at the second completing edge
        send_word(4'b0101, 1'b0);
        send_word(4'b1010, 1'b1);
        chk("b2b_dout", 32'(dout), 32'hA);
        chk("b2b_valid", 32'(dout_valid), 32'h1);
        chk("b2b_ovr", 32'(overrun), 32'h0);

        // clear aborts a partial word and masks a simultaneous strobe
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("abort_busy", 32'(busy), 32'h0);
        send_word(4'b0001, 1'b1);
        chk("abort_dout", 32'(dout), 32'h1);

        // asynchronous reset mid-word
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_dout", 32'(dout), 32'h0);
        chk("arst_valid", 32'(dout_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_ovr", 32'(overrun), 32'h0);
        bit_en = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_word(4'b0110, 1'b0);
        chk("post_rst_dout", 32'(dout), 32'h6);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) < 3), 1'($urandom_range(0, 1)));
        end

        // drain: one accepting cycle with no new bits leaves nothing outstanding
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_register_deserializer.md
Name: shift_register_deserializer

Overview:
- Receiving end of the serial link driven by our parallel-load shift register; it reassembles serial bits into N-bit words.
- The transmitter shifts right and presents bit 0 first, so this block receives LSB first.
- Each completed word is presented on a parallel output with a valid/ready handshake. An overrun flag records any word lost because the consumer stalled.
- Sits between the serial line (plus its bit strobe) and a parallel consumer.

Parameters:
- N, 4, word width in bits; legal range N >= 2.
- CW, 2, bit-counter width; must equal $clog2(N).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- si  input  1  serial data in; sampled only when bit_en = 1.
- bit_en  input  1  bit strobe; one received bit per clk cycle in which it is high.
- clear  input  1  synchronous abort of the partial word; also clears overrun.
- dout  output  N  last completed word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout in this cycle.
- busy  output  1  high while a partial word is being collected (bit count != 0).
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (asynchronous, reset_n = 0) clears all state:
  - shift register sh = 0, bit count cnt = 0
  - dout = 0, dout_valid = 0, overrun = 0, busy = 0
- Priority per cycle: clear > bit_en.
- clear = 1 at a clock edge:
  - sh <= 0, cnt <= 0, overrun <= 0.
  - dout and dout_valid are unchanged; the handshake still completes normally in the same cycle.
  - bit_en in the same cycle is ignored.
- Shift, on bit_en = 1 with clear = 0: sh <= {si, sh[N-1:1]}.
- Bit counting:
  - If cnt < N-1: cnt <= cnt + 1.
  - If cnt = N-1: the word completes. Define w = {si, sh[N-1:1]}; cnt wraps to 0.
  - After N strobes, the first-received bit is at dout[0] and the last at dout[N-1].
- Consume event C is dout_valid & dout_ready. On C with no completion that cycle: dout_valid <= 0 and dout holds its value.
- On completion, the output register is updated as follows:
  - dout_valid = 0: dout <= w, dout_valid <= 1.
  - dout_valid = 1 and C: dout <= w, dout_valid stays 1. This is back-to-back and is not an overrun.
  - dout_valid = 1 and not C: w is discarded, dout is unchanged, overrun <= 1.
- Latency: dout_valid rises at the edge that samples the N-th bit. A strobe on every cycle gives one word per N cycles.
- dout_ready while dout_valid = 0 has no effect.
- busy = (cnt != 0), combinational from cnt.
- Gaps between strobes (bit_en low) hold sh and cnt indefinitely.
- Reset mid-word discards the partial word. reset_n dominates clear.

Test Plan:
- Reset, then bits 1,0,1,1 with bit_en on 4 consecutive cycles and dout_ready = 0 -> dout = 4'b1101, dout_valid = 1 after the 4th edge; busy = 1 after edges 1-3 and 0 after edge 4; overrun = 0.
- With dout_valid = 1 and 4'b1101 pending, pulse dout_ready for one cycle -> dout_valid = 0 next cycle, dout stays 4'b1101.
- Word 4'b0011 pending, dout_ready = 0, send 1,1,1,1 -> overrun = 1, dout = 4'b0011. Then clear = 1 -> overrun = 0, cnt = 0, dout_valid still 1.
- Continuous strobe with dout_ready = 1 at the completing edge of the second word; words 4'b0101 then 4'b1010 -> dout = 4'b1010, dout_valid stays 1, overrun = 0.
- Send 2 bits, assert clear together with a 3rd bit_en, then send 1,0,0,0 -> dout = 4'b0001; the first 2 bits and the ignored bit have no effect.
- Send 3 bits, drop reset_n asynchronously between edges -> all outputs 0 immediately. After release, 4 bits 0,1,1,0 -> dout = 4'b0110.
